memory_responder: RTL and testbench

Word-addressed synchronous RAM that services the datapath's memory port: it samples the `Read`/`Write` strobes, address from MAR and write data from MDR, and returns read data on `Mdatain` with a one-cycle `mem_ready` pulse. It sits outside `DataPath`, on the memory side of the MAR/MDR interface that the control sequencer drives during ld/st. It adds a fixed, parameterised wait-state count so the control unit can be exercised against a slow memory.

---
 rtl/memory_responder.sv | 86 ++++++++
 tb/tb_memory_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: word-addressed RAM with fixed wait states behind the MAR/MDR port.
// Define MEM_BUSERR_EN to flag out-of-range addresses instead of wrapping them.
module memory_responder #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] MAR_addr,
    input  logic [31:0] MDR_wdata,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        bus_err
);
`ifdef MEM_BUSERR_EN
    localparam bit BUSERR = 1'b1;
`else
    localparam bit BUSERR = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] idx;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];
    logic rd_q, wr_q, oor_q, oor_in;
    logic req, capture, access, do_wr, do_rd;

    assign req    = Read | Write;
    assign oor_in = BUSERR && (MAR_addr >= 32'(DEPTH));

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (req ? ((WAIT_CYCLES > 0) ? WAIT : ACCESS) : IDLE) :
                   (state == WAIT) ? ((cnt == 4'd0) ? ACCESS : WAIT) : IDLE;
    end

    always_comb begin
        capture  = (state == IDLE) && req;
        access   = (state == ACCESS);
        do_wr    = access && wr_q && !oor_q;
        do_rd    = access && rd_q && !wr_q;
        mem_busy = (state != IDLE);
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            cnt       <= '0;
            idx       <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            oor_q     <= 1'b0;
            Mdatain   <= '0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if (capture) begin
                idx     <= MAR_addr[ADDR_W-1:0];
                wdata_q <= MDR_wdata;
                rd_q    <= Read;
                wr_q    <= Write;
                oor_q   <= oor_in;
                cnt     <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (do_rd) Mdatain <= oor_q ? 32'd0 : mem[idx];
            mem_ready <= access;
            bus_err   <= access && oor_q;
        end
    end

    // RAM array is deliberately outside the reset domain
    always_ff @(posedge Clock) begin
        if (do_wr) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: two responders (0 and 3 wait states) on shared stimulus, checked
// every cycle against a transaction-level model; honours MEM_BUSERR_EN when defined.
module tb_memory_responder;
`ifdef MEM_BUSERR_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif
    logic clk = 1'b0, clear = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] d0, d1;
    logic r0, r1, b0, b1, e0, e1;
    int n_vec = 0, n_fail = 0;

    memory_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(0)) u0 (
        .Clock(clk), .clear(clear), .MAR_addr(addr), .MDR_wdata(wdata), .Read(rd), .Write(wr),
        .Mdatain(d0), .mem_ready(r0), .mem_busy(b0), .bus_err(e0));
    memory_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_CYCLES(3)) u1 (
        .Clock(clk), .clear(clear), .MAR_addr(addr), .MDR_wdata(wdata), .Read(rd), .Write(wr),
        .Mdatain(d1), .mem_ready(r1), .mem_busy(b1), .bus_err(e1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a captured access completes a fixed number of edges later (waits + 1).
    bit          m_busy [2];
    int          m_rem  [2];
    bit          m_rd [2], m_wr [2], m_oor [2];
    int          m_idx  [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_mem  [2][512];
    bit          m_kn   [2][512];
    logic [31:0] x_d [2];
    bit          x_dk [2], x_r [2], x_e [2];

    always @(posedge clk or negedge clear) begin
        for (int i = 0; i < 2; i++) begin
            if (!clear) begin
                m_busy[i] = 0; x_d[i] = '0; x_dk[i] = 1; x_r[i] = 0; x_e[i] = 0;
            end else if (!m_busy[i]) begin
                x_r[i] = 0; x_e[i] = 0;
                if (rd || wr) begin
                    m_busy[i] = 1;
                    m_rem[i]  = (i == 1 ? 3 : 0) + 1;
                    m_rd[i]   = rd;
                    m_wr[i]   = wr;
                    m_idx[i]  = int'(addr % 512);
                    m_wd[i]   = wdata;
                    m_oor[i]  = BE && (addr >= 512);
                end
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_busy[i] = 0; x_r[i] = 1; x_e[i] = m_oor[i];
                    if (m_wr[i]) begin
                        if (!m_oor[i]) begin
                            m_mem[i][m_idx[i]] = m_wd[i]; m_kn[i][m_idx[i]] = 1;
                        end
                    end else if (m_oor[i]) begin
                        x_d[i] = '0; x_dk[i] = 1;
                    end else begin
                        x_d[i] = m_mem[i][m_idx[i]]; x_dk[i] = m_kn[i][m_idx[i]];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("ready0", {31'd0, r0}, {31'd0, x_r[0]});
        chk("busy0",  {31'd0, b0}, {31'd0, m_busy[0]});
        chk("err0",   {31'd0, e0}, {31'd0, x_e[0]});
        if (x_dk[0]) chk("data0", d0, x_d[0]);
        chk("ready1", {31'd0, r1}, {31'd0, x_r[1]});
        chk("busy1",  {31'd0, b1}, {31'd0, m_busy[1]});
        chk("err1",   {31'd0, e1}, {31'd0, x_e[1]});
        if (x_dk[1]) chk("data1", d1, x_d[1]);
    end

    task automatic wait_idle();
        for (int c = 0; c < 20 && (b0 || b1); c++) @(negedge clk);
        chk("idle_timeout", {30'd0, b0, b1}, 32'd0);
    endtask

    // Holds the strobes until the slow responder completes; returns its data and error flag.
    task automatic mem_op(input logic r_, input logic w_, input logic [31:0] a, input logic [31:0] dat,
                          output logic [31:0] data, output logic err);
        bit got = 0;
        rd = r_; wr = w_; addr = a; wdata = dat; data = '0; err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (r1) begin
                data = d1; err = e1; got = 1;
                break;
            end
        end
        chk("ready_timeout", {31'd0, got}, 32'd1);
        rd = 1'b0; wr = 1'b0;
        wait_idle();
    endtask

    logic [31:0] dv;
    logic        ev;
    int          pulses;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_d0", d0, 0); chk("rst_r0", {31'd0, r0}, 0); chk("rst_b0", {31'd0, b0}, 0);
        chk("rst_e0", {31'd0, e0}, 0); chk("rst_d1", d1, 0); chk("rst_b1", {31'd0, b1}, 0);
        clear = 1'b1;
        @(negedge clk);
        mem_op(0, 1, 3, 32'h0000_00A5, dv, ev);
        mem_op(1, 0, 3, 0, dv, ev);
        chk("rd3_u1", dv, 32'h0000_00A5);
        chk("rd3_u0", d0, 32'h0000_00A5);
        mem_op(0, 1, 7, 32'h1234_5678, dv, ev);
        mem_op(0, 1, 8, 32'hCAFE_0008, dv, ev);
        rd = 1'b1; addr = 7;
        @(negedge clk);
        chk("lat_b1_0", {31'd0, b1}, 1); chk("lat_r1_0", {31'd0, r1}, 0);
        addr = 8;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("lat_b1_%0d", c), {31'd0, b1}, (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("lat_r1_%0d", c), {31'd0, r1}, (c == 4) ? 32'd1 : 32'd0);
        end
        chk("lat_d1", d1, 32'h1234_5678);
        rd = 1'b0;
        wait_idle();
        mem_op(1, 1, 10, 32'hDEAD_BEEF, dv, ev);
        chk("rw_keep_d1", d1, 32'h1234_5678);
        chk("rw_keep_d0", d0, 32'hCAFE_0008);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(r1);
        end
        chk("rw_single_pulse", pulses, 0);
        mem_op(1, 0, 10, 0, dv, ev);
        chk("rd10", dv, 32'hDEAD_BEEF);
        rd = 1'b1; addr = 3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("held_r0_%0d", c), {31'd0, r0}, 32'(c % 2));
        end
        rd = 1'b0;
        wait_idle();
        chk("held_d0", d0, 32'h0000_00A5);
        mem_op(0, 1, 5, 32'h11, dv, ev);
        wr = 1'b1; addr = 5; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        wr = 1'b0; clear = 1'b0;
        #1;
        chk("clr_b1", {31'd0, b1}, 0); chk("clr_d1", d1, 0); chk("clr_r1", {31'd0, r1}, 0);
        chk("clr_b0", {31'd0, b0}, 0); chk("clr_d0", d0, 0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        mem_op(1, 0, 5, 0, dv, ev);
        chk("clr_rd5_u1", dv, 32'h11);
        chk("clr_rd5_u0", d0, 32'h11);
        mem_op(0, 1, 0, 32'h77, dv, ev);
        mem_op(1, 0, 32'h200, 0, dv, ev);
        chk("oor_rd_d", dv, BE ? 32'd0 : 32'h77);
        chk("oor_rd_e", {31'd0, ev}, BE ? 32'd1 : 32'd0);
        mem_op(0, 1, 32'h200, 32'h55, dv, ev);
        mem_op(1, 0, 0, 0, dv, ev);
        chk("oor_wr_ram0", dv, BE ? 32'h77 : 32'h55);
        repeat (1500) begin
            @(negedge clk);
            clear = ($urandom_range(0, 199) != 0);
            rd    = ($urandom_range(0, 2) == 0);
            wr    = ($urandom_range(0, 3) == 0);
            addr  = 32'($urandom_range(0, 15)) | (($urandom_range(0, 5) == 0) ? 32'h200 : 32'h0);
            wdata = $urandom;
        end
        @(negedge clk);
        clear = 1'b1; rd = 1'b0; wr = 1'b0;
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
